// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared defaults and helpers for the register file
// Contents: XLEN/REG_AW defaults, one-hot width helper, ZERO_REG convention constant.
package regfile_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    // Convention: entry 0 is hard-wired to zero unless a build overrides it.
    localparam bit ZERO_REG_HARDWIRED = 1'b1;

    // Number of entries / one-hot lines addressed by an aw-bit index.
    function automatic int onehot_w(input int aw);
        return 1 << aw;
    endfunction

endpackage

// File: rtl/decoder_onehot.sv
// rtl/decoder_onehot.sv - generic combinational binary to one-hot decoder
// Ports: in[AW-1:0] index, en enable, out[2**AW-1:0] = en ? (1 << in) : 0.
module decoder_onehot
    import regfile_pkg::*;
#(
    parameter int AW = REG_AW
) (
    input  logic [AW-1:0]              in,
    input  logic                       en,
    output logic [onehot_w(AW)-1:0]    out
);

    always_comb begin
        out = '0;
        if (en) begin
            out[in] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_nrp.sv
// rtl/regfile_nrp.sv - parametrised register file, one write port, NUM_RD combinational read ports
// Ports: clk, rst (sync, active-high), we/waddr/wdata write port,
//        raddr/rdata packed read ports (port k at [k*W +: W]), wsel registered write one-hot.
// Optional feature: REGFILE_BYPASS_EN enables same-cycle write-through to the read ports.
module regfile_nrp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = XLEN,
    parameter int ADDR_W   = REG_AW,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = ZERO_REG_HARDWIRED
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        we,
    input  logic [ADDR_W-1:0]           waddr,
    input  logic [DATA_W-1:0]           wdata,
    input  logic [NUM_RD*ADDR_W-1:0]    raddr,
    output logic [NUM_RD*DATA_W-1:0]    rdata,
    output logic [onehot_w(ADDR_W)-1:0] wsel
);

    localparam int DEPTH = onehot_w(ADDR_W);

    logic [DEPTH-1:0]  dec;
    logic [DEPTH-1:0]  wen;
    logic [DATA_W-1:0] mem [DEPTH];

    decoder_onehot #(.AW(ADDR_W)) u_wdec (
        .in  (waddr),
        .en  (we),
        .out (dec)
    );

    // Entry 0 never gets an enable when it is hard-wired, so wsel also
    // records all-zeros for such a write.
    always_comb begin
        wen = dec;
        if (ZERO_REG) begin
            wen[0] = 1'b0;
        end
    end

    // Reset wins over a coincident write; that write is dropped entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wsel <= '0;
        end else if (we) begin
            wsel <= wen;
            for (int i = 0; i < DEPTH; i++) begin
                if (wen[i]) begin
                    mem[i] <= wdata;
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd;

        assign ra = raddr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rd = mem[ra];
`ifdef REGFILE_BYPASS_EN
            // Write-through is held off during reset so readers see the cleared state.
            if (we && !rst && (ra == waddr)) begin
                rd = wdata;
            end
`endif
            // Applied last so the hard-wired zero also overrides the bypass.
            if (ZERO_REG && (ra == '0)) begin
                rd = '0;
            end
        end

        assign rdata[k*DATA_W +: DATA_W] = rd;
    end

endmodule
